// File: rtl/axi_pkg.sv
// Shared AXI/AHB encodings used by the master and the memory slave.
package axi_pkg;
    typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} axi_resp_t;
    typedef enum logic [1:0] {IDLE = 2'b00, NON_SEQ = 2'b10, SEQ = 2'b11} htrans_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_slave_mem_if.sv
// AW/W/B and AR/R channel bundle between axi_master and axi_slave_mem.
interface axi_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid, awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid, wready;
    logic [1:0]              bresp;
    logic                    bvalid, bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid, arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast, rvalid, rready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wstrb, wvalid, bready, araddr, arlen, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awaddr, awlen, awvalid, wdata, wstrb, wvalid, bready, araddr, arlen, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_array.sv
// Word array with one byte-enabled write port and one registered read port
// (read-before-write on a same-word collision).
module axi_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
    input  logic                         re_i,
    input  logic                         rclr_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // rclr_i substitutes zero for an out-of-range beat
    always_ff @(posedge clk) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_slave_mem.sv
// AXI-style memory slave: independent write and read FSMs over one shared array.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    axi_slave_mem_if.slave bus
);
    localparam int OFF = $clog2(DATA_WIDTH/8);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    wstate_t               w_q, w_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  awready_q, wready_q, bvalid_q;
    axi_resp_t             bresp_q, bresp_d;
    logic                  aw_hs, w_hs, b_hs, w_oor, mem_we;

    rstate_t               r_q, r_d;
    logic [ADDR_WIDTH-1:0] ridx_q, ridx_d, load_idx;
    logic [7:0]            rrem_q, rrem_d;
    logic                  arready_q, rvalid_q, rlast_q, rlast_d;
    axi_resp_t             rresp_q, rresp_d;
    logic                  ar_hs, r_hs, mem_re, load_oor;

    assign aw_hs = bus.awvalid & awready_q;
    assign w_hs  = bus.wvalid  & wready_q;
    assign b_hs  = bvalid_q    & bus.bready;
    assign w_oor = widx_q >= DEPTH;
    assign ar_hs = bus.arvalid & arready_q;
    assign r_hs  = rvalid_q    & bus.rready;

    always_comb begin
        w_d = w_q; widx_d = widx_q; wlen_d = wlen_q; wcnt_d = wcnt_q;
        werr_d = werr_q; bresp_d = bresp_q; mem_we = 1'b0;
        case (w_q)
            W_IDLE: if (aw_hs) begin
                widx_d = bus.awaddr >> OFF;
                wlen_d = bus.awlen;
                wcnt_d = '0;
                werr_d = 1'b0;
                w_d    = W_DATA;
            end
            W_DATA: if (w_hs) begin
                mem_we = !w_oor;
                werr_d = werr_q | w_oor;
                widx_d = widx_q + 1'b1;
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == wlen_q) begin
                    w_d     = W_RESP;
                    bresp_d = werr_d ? SLVERR : OKAY;
                end
            end
            W_RESP: if (b_hs) w_d = W_IDLE;
            default: w_d = W_IDLE;
        endcase
    end

    // The next beat is loaded into the array read register on the accepting edge
    always_comb begin
        r_d = r_q; ridx_d = ridx_q; rrem_d = rrem_q; rlast_d = rlast_q; rresp_d = rresp_q;
        mem_re = 1'b0; load_idx = ridx_q; load_oor = 1'b0;
        case (r_q)
            R_IDLE: if (ar_hs) begin
                load_idx = bus.araddr >> OFF;
                rrem_d   = bus.arlen;
                mem_re   = 1'b1;
                r_d      = R_DATA;
            end
            R_DATA: if (r_hs) begin
                if (rlast_q) r_d = R_IDLE;
                else begin
                    mem_re = 1'b1;
                    rrem_d = rrem_q - 8'd1;
                end
            end
            default: r_d = R_IDLE;
        endcase
        if (mem_re) begin
            load_oor = load_idx >= DEPTH;
            ridx_d   = load_idx + 1'b1;
            rlast_d  = rrem_d == 8'd0;
            rresp_d  = load_oor ? SLVERR : OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q <= W_IDLE; widx_q <= '0; wlen_q <= '0; wcnt_q <= '0; werr_q <= 1'b0;
            awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= OKAY;
            r_q <= R_IDLE; ridx_q <= '0; rrem_q <= '0;
            arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0; rresp_q <= OKAY;
        end else begin
            w_q <= w_d; widx_q <= widx_d; wlen_q <= wlen_d; wcnt_q <= wcnt_d; werr_q <= werr_d;
            awready_q <= (w_d == W_IDLE);
            wready_q  <= (w_d == W_DATA);
            bvalid_q  <= (w_d == W_RESP);
            bresp_q   <= bresp_d;
            r_q <= r_d; ridx_q <= ridx_d; rrem_q <= rrem_d;
            arready_q <= (r_d == R_IDLE);
            rvalid_q  <= (r_d == R_DATA);
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_mem_array #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we & rst_n),
        .waddr_i (widx_q[IW-1:0]),
        .wdata_i (bus.wdata),
        .wstrb_i (bus.wstrb),
        .re_i    (mem_re),
        .rclr_i  (load_oor),
        .raddr_i (load_idx[IW-1:0]),
        .rdata_o (bus.rdata)
    );

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rresp   = rresp_q;
endmodule
